// File: rtl/shift_tx_pkg.sv
// Purpose: shared types and default sizing for the serial transmit controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shift_tx_pkg;

  // Frame sequencing states; the line is idle high in IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_BIT_CYCLES = 4;

endpackage

// File: rtl/shiftreg_en.sv
// Purpose: parallel-load, left-shifting register feeding the serial line MSB-first.
// Latency: load or shift takes effect on the next rising edge.
// Backpressure: none; load has priority over shift enable.
module shiftreg_en #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic             sin,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load a new word, otherwise shift left pulling sin into the LSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (en) begin
      q <= {q[WIDTH-2:0], sin};
    end
  end

endmodule

// File: rtl/shift_tx_ctrl.sv
// Purpose: frames a parallel byte as start(0) + data MSB-first + stop(1) on a registered serial line.
// Latency: sout goes low the edge after the handshake; done pulses (WIDTH+2)*BIT_CYCLES clocks later.
// Backpressure: tx_ready is high only in IDLE (and not in reset); a frame in flight is never reloaded.
module shift_tx_ctrl
  import shift_tx_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int CYC_W = $clog2(BIT_CYCLES) + 1;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  tx_state_t        r_state;
  tx_state_t        w_state_nxt;
  logic [CYC_W-1:0] r_bit_cyc;
  logic [CYC_W-1:0] w_bit_cyc_nxt;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] w_bit_cnt_nxt;
  logic             r_sout;
  logic             w_sout_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_load;
  logic             w_shift_en;
  logic             w_cyc_last;
  logic             w_hs;
  logic [WIDTH-1:0] w_q;

  // Ready is gated by reset so a producer never handshakes into a clearing controller.
  assign tx_ready   = (r_state == IDLE) && !reset;
  assign w_hs       = tx_valid && tx_ready;
  assign w_cyc_last = (r_bit_cyc == CYC_LAST);

  assign sout = r_sout;
  assign done = r_done;
  assign busy = (r_state != IDLE);

  shiftreg_en #(
    .WIDTH (WIDTH)
  ) u_shiftreg (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .en    (w_shift_en),
    .sin   (1'b0),
    .d     (tx_data),
    .q     (w_q)
  );

  // State, counters and registered line outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_bit_cyc <= '0;
      r_bit_cnt <= '0;
      r_sout    <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cyc <= w_bit_cyc_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_sout    <= w_sout_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Next-state, counter and output decode; sout always reflects the bit about to be on the line.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cyc_nxt = r_bit_cyc;
    w_bit_cnt_nxt = r_bit_cnt;
    w_sout_nxt    = r_sout;
    w_done_nxt    = 1'b0;
    w_load        = 1'b0;
    w_shift_en    = 1'b0;

    case (r_state)
      IDLE: begin
        w_sout_nxt = 1'b1;
        if (w_hs) begin
          w_load        = 1'b1;
          w_sout_nxt    = 1'b0;
          w_bit_cyc_nxt = '0;
          w_state_nxt   = START;
        end
      end

      START: begin
        if (w_cyc_last) begin
          w_sout_nxt    = w_q[WIDTH-1];
          w_bit_cyc_nxt = '0;
          w_bit_cnt_nxt = '0;
          w_state_nxt   = DATA;
        end else begin
          w_bit_cyc_nxt = r_bit_cyc + CYC_ONE;
        end
      end

      DATA: begin
        if (w_cyc_last) begin
          // End of a bit: advance the register and count it; the last bit hands over to stop.
          w_bit_cyc_nxt = '0;
          w_shift_en    = 1'b1;
          w_bit_cnt_nxt = r_bit_cnt + CNT_ONE;
          if (r_bit_cnt == CNT_LAST) begin
            w_sout_nxt  = 1'b1;
            w_state_nxt = STOP;
          end else begin
            w_sout_nxt  = w_q[WIDTH-2];
          end
        end else begin
          w_bit_cyc_nxt = r_bit_cyc + CYC_ONE;
        end
      end

      STOP: begin
        w_sout_nxt = 1'b1;
        if (w_cyc_last) begin
          w_bit_cyc_nxt = '0;
          w_done_nxt    = 1'b1;
          w_state_nxt   = IDLE;
        end else begin
          w_bit_cyc_nxt = r_bit_cyc + CYC_ONE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_sout_nxt  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_tx_ctrl.sv
// Purpose: bench for shift_tx_ctrl with one instance at BIT_CYCLES=2 and one at BIT_CYCLES=1.
// Latency: n/a.
// Backpressure: producer side honours tx_ready.
module tb_shift_tx_ctrl;

  logic       clk;
  logic       rst0, rst1;
  logic [7:0] data0, data1;
  logic       vld0, vld1;
  logic       rdy0, rdy1;
  logic       sout0, sout1;
  logic       busy0, busy1;
  logic       done0, done1;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  logic q_sout0[$];
  logic q_sout1[$];
  int   q_done0[$];
  int   q_done1[$];

  shift_tx_ctrl #(.WIDTH(8), .BIT_CYCLES(2)) u_dut0 (
    .clk(clk), .reset(rst0), .tx_data(data0), .tx_valid(vld0),
    .tx_ready(rdy0), .sout(sout0), .busy(busy0), .done(done0)
  );

  shift_tx_ctrl #(.WIDTH(8), .BIT_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(rst1), .tx_data(data1), .tx_valid(vld1),
    .tx_ready(rdy1), .sout(sout1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_sout(input int idx, input logic b);
    if (idx == 0) q_sout0.push_back(b);
    else          q_sout1.push_back(b);
  endtask

  task automatic push_done(input int idx, input int c);
    if (idx == 0) q_done0.push_back(c);
    else          q_done1.push_back(c);
  endtask

  function automatic logic rdy_of(input int idx);
    return (idx == 0) ? rdy0 : rdy1;
  endfunction

  function automatic int pending(input int idx);
    return (idx == 0) ? (q_sout0.size() + q_done0.size())
                      : (q_sout1.size() + q_done1.size());
  endfunction

  // Offer a byte; frame holds the hand-computed line bits start..stop, MSB first.
  task automatic send(input int idx, input logic [7:0] d, input logic [9:0] frame,
                      output int hs_cyc);
    int   bc;
    int   waited;
    logic rdy;
    bc = (idx == 0) ? 2 : 1;
    if (idx == 0) begin data0 = d; vld0 = 1'b1; end
    else          begin data1 = d; vld1 = 1'b1; end
    waited = 0;
    rdy    = rdy_of(idx);
    while (!rdy && waited < 200) begin
      @(posedge clk); #1;
      waited++;
      rdy = rdy_of(idx);
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout dut%0d: tx_ready got 0 expected 1", idx);
      hs_cyc = -1;
      return;
    end
    for (int b = 9; b >= 0; b--)
      for (int k = 0; k < bc; k++)
        push_sout(idx, frame[b]);
    push_done(idx, cyc + 1 + 10 * bc);
    hs_cyc = cyc + 1;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int idx);
    int n;
    n = 0;
    while (pending(idx) != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("drain_dut%0d_pending", idx), pending(idx), 0);
    @(posedge clk); #1;
  endtask

  // Line and done monitor for the BIT_CYCLES=2 instance.
  always @(negedge clk) begin
    if (rst0 === 1'b0) begin
      if (busy0) begin
        if (q_sout0.size() == 0) check("sout0_unexpected_busy", 1, 0);
        else                     check("sout0", sout0, q_sout0.pop_front());
      end
      if (done0) begin
        check("done0_busy", busy0, 0);
        if (q_done0.size() == 0) check("done0_unexpected", 1, 0);
        else                     check("done0_cycle", cyc, q_done0.pop_front());
      end
    end
  end

  // Line and done monitor for the BIT_CYCLES=1 instance.
  always @(negedge clk) begin
    if (rst1 === 1'b0) begin
      if (busy1) begin
        if (q_sout1.size() == 0) check("sout1_unexpected_busy", 1, 0);
        else                     check("sout1", sout1, q_sout1.pop_front());
      end
      if (done1) begin
        check("done1_busy", busy1, 0);
        if (q_done1.size() == 0) check("done1_unexpected", 1, 0);
        else                     check("done1_cycle", cyc, q_done1.pop_front());
      end
    end
  end

  initial begin
    int hs_a;
    int hs_b;
    rst0  = 1'b1; rst1  = 1'b1;
    vld0  = 1'b0; vld1  = 1'b0;
    data0 = 8'h00; data1 = 8'h00;

    // Reset held for two clocks.
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_sout0",  sout0, 1);
    check("rst_ready0", rdy0,  0);
    check("rst_busy0",  busy0, 0);
    check("rst_done0",  done0, 0);
    check("rst_sout1",  sout1, 1);
    check("rst_ready1", rdy1,  0);
    rst0 = 1'b0; rst1 = 1'b0;
    #1;
    check("post_rst_ready0", rdy0, 1);
    check("post_rst_ready1", rdy1, 1);

    // Idle line with no valid.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle_sout0", sout0, 1);
      check("idle_busy0", busy0, 0);
    end

    // 8'hAA at two clocks per bit.
    send(0, 8'hAA, 10'b0101010101, hs_a);
    vld0 = 1'b0;
    wait_idle(0);

    // 8'h81 then 8'h3C back to back at one clock per bit.
    send(1, 8'h81, 10'b0100000011, hs_a);
    send(1, 8'h3C, 10'b0001111001, hs_b);
    vld1 = 1'b0;
    check("b2b_handshake_cycle", hs_b, hs_a + 11);
    wait_idle(1);

    // Mid-frame data change and valid pulse are ignored.
    send(0, 8'h55, 10'b0010101011, hs_a);
    vld0 = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    data0 = 8'hFF;
    vld0  = 1'b1;
    check("midframe_ready0", rdy0, 0);
    @(posedge clk); #1;
    vld0 = 1'b0;
    wait_idle(0);

    // Reset during data bit 3 aborts the frame.
    send(0, 8'h96, 10'b0100101101, hs_a);
    vld0 = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    check("pre_abort_busy0", busy0, 1);
    rst0 = 1'b1;
    q_sout0.delete();
    q_done0.delete();
    @(posedge clk); #1;
    check("abort_sout0", sout0, 1);
    check("abort_busy0", busy0, 0);
    check("abort_done0", done0, 0);
    rst0 = 1'b0;
    #1;
    check("abort_ready0", rdy0, 1);
    send(0, 8'h0F, 10'b0000011111, hs_a);
    vld0 = 1'b0;
    wait_idle(0);

    repeat (3) begin @(posedge clk); #1; end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
